// File: rtl/uart_tx.sv
// uart_tx - serial transmitter, 8N1-style frames with configurable width,
// parity and stop bits.
//
// Frame: start (0), DATA_WIDTH data bits LSB first, optional parity bit,
// STOP_BITS stop bits (1). Every bit lasts max(uart_cnt,1) clocks, with
// uart_cnt latched together with the data when the request is accepted.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   uart_cnt   clocks per bit (0 is treated as 1)
//   uart_en    transmit request, taken only while idle
//   uart_din   data word, sampled with uart_en
//   uart_txd   registered serial output, idle high
//   uart_busy  high while a frame is on the line
//   uart_done  one-cycle pulse after the last stop bit
module uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           uart_cnt,
    input  logic                  uart_en,
    input  logic [DATA_WIDTH-1:0] uart_din,
    output logic                  uart_txd,
    output logic                  uart_busy,
    output logic                  uart_done
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    state_t                r_state, w_state_nxt;
    logic [15:0]           r_cnt, r_period, w_period_in;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
    logic [3:0]            r_idx, w_idx_nxt;
    logic                  r_par;
    logic                  r_txd, r_busy, r_done;
    logic                  w_txd_nxt, w_busy_nxt, w_done_nxt;
    logic                  w_bit_end, w_accept;

    // Counter reaching zero marks the last clock of the current bit.
    assign w_bit_end   = (r_cnt == 16'd0);
    assign w_accept    = (r_state == S_IDLE) && uart_en;
    assign w_period_in = (uart_cnt == 16'd0) ? 16'd1 : uart_cnt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (uart_en) w_state_nxt = S_START;
            S_START: if (w_bit_end) w_state_nxt = S_DATA;
            S_DATA:  if (w_bit_end && r_idx == LAST_DATA)
                         w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:   if (w_bit_end) w_state_nxt = S_STOP;
            S_STOP:  if (w_bit_end && r_idx == LAST_STOP) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values. txd is computed one clock ahead so the
    // line itself comes straight from a flop.
    always_comb begin
        w_idx_nxt = r_idx;
        if (w_state_nxt != r_state)
            w_idx_nxt = 4'd0;
        else if (w_bit_end && (r_state == S_DATA || r_state == S_STOP))
            w_idx_nxt = r_idx + 4'd1;

        // Shift only between data bits; START->DATA presents bit 0 unshifted.
        w_shift_nxt = r_shift;
        if (r_state == S_DATA && w_bit_end)
            w_shift_nxt = r_shift >> 1;

        case (w_state_nxt)
            S_START: w_txd_nxt = 1'b0;
            S_DATA:  w_txd_nxt = w_shift_nxt[0];
            S_PAR:   w_txd_nxt = r_par;
            default: w_txd_nxt = 1'b1;
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (r_state == S_STOP) && (w_state_nxt == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= 16'd0;
            r_period <= 16'd0;
            r_shift  <= '0;
            r_idx    <= 4'd0;
            r_par    <= 1'b0;
            r_txd    <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_txd  <= w_txd_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            r_idx  <= w_idx_nxt;
            if (w_accept) begin
                r_period <= w_period_in;
                r_cnt    <= w_period_in - 16'd1;
                r_shift  <= uart_din;
                // Even parity = XOR of data; odd inverts it.
                r_par    <= (^uart_din) ^ (PARITY == 1);
            end else begin
                r_shift <= w_shift_nxt;
                if (r_state == S_IDLE)
                    r_cnt <= 16'd0;
                else if (w_bit_end)
                    r_cnt <= (w_state_nxt == S_IDLE) ? 16'd0 : r_period - 16'd1;
                else
                    r_cnt <= r_cnt - 16'd1;
            end
        end
    end

    assign uart_txd  = r_txd;
    assign uart_busy = r_busy;
    assign uart_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (8N1, 8E1, 8O1, 8N2) share one stimulus.
// A queue-based frame model predicts txd/busy/done every cycle; literal
// checks pin frame lengths, parity values, back-to-back timing and reset.
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [15:0] cnt = 16'd4;
    logic [3:0]  txd, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx #(.DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .uart_cnt(cnt), .uart_en(en), .uart_din(din),
        .uart_txd(txd[0]), .uart_busy(busy[0]), .uart_done(done[0]));
    uart_tx #(.DATA_WIDTH(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .uart_cnt(cnt), .uart_en(en), .uart_din(din),
        .uart_txd(txd[1]), .uart_busy(busy[1]), .uart_done(done[1]));
    uart_tx #(.DATA_WIDTH(8), .PARITY(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .uart_cnt(cnt), .uart_en(en), .uart_din(din),
        .uart_txd(txd[2]), .uart_busy(busy[2]), .uart_done(done[2]));
    uart_tx #(.DATA_WIDTH(8), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst_n(rst_n), .uart_cnt(cnt), .uart_en(en), .uart_din(din),
        .uart_txd(txd[3]), .uart_busy(busy[3]), .uart_done(done[3]));

    int par_m[4] = '{0, 2, 1, 0};
    int stp_m[4] = '{1, 1, 1, 2};

    // Model: per instance, a queue holding the txd level of every remaining
    // cycle of the current frame. Empty queue = idle line.
    bit   mq[4][$];
    logic [3:0] e_txd = 4'hF, e_busy = 4'h0, e_done = 4'h0;

    function automatic void push_frame(int i, logic [7:0] d, logic [15:0] c);
        int p;
        bit fb[$];
        p = (c == 16'd0) ? 1 : int'(c);
        fb.push_back(1'b0);
        for (int k = 0; k < 8; k++) fb.push_back(d[k]);
        if (par_m[i] == 2) fb.push_back(^d);
        if (par_m[i] == 1) fb.push_back(~^d);
        for (int k = 0; k < stp_m[i]; k++) fb.push_back(1'b1);
        foreach (fb[b]) repeat (p) mq[i].push_back(fb[b]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            e_txd  = 4'hF;
            e_busy = 4'h0;
            e_done = 4'h0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                bit was_idle;
                was_idle = (mq[i].size() == 0);
                e_done[i] = 1'b0;
                if (!was_idle) begin
                    void'(mq[i].pop_front());
                    if (mq[i].size() == 0) e_done[i] = 1'b1;
                end
                if (was_idle && en) push_frame(i, din, cnt);
                e_txd[i]  = (mq[i].size() != 0) ? mq[i][0] : 1'b1;
                e_busy[i] = (mq[i].size() != 0);
            end
        end
    end

    task automatic chk(string nm, int i, logic act, logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] got %0b expected %0b at %0t", nm, i, act, exp, $time);
        end
    endtask

    task automatic chkv(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare plus per-instance activity counters.
    int bcnt[4], dcnt[4], lcnt[4];
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            chk("txd",  i, txd[i],  e_txd[i]);
            chk("busy", i, busy[i], e_busy[i]);
            chk("done", i, done[i], e_done[i]);
            if (busy[i]) bcnt[i]++;
            if (done[i]) dcnt[i]++;
            if (!txd[i]) lcnt[i]++;
        end
    end

    task automatic clr();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            bcnt[i] = 0; dcnt[i] = 0; lcnt[i] = 0;
        end
    endtask

    // Pulse uart_en for one edge; returns at the negedge of frame cycle 0.
    task automatic send(logic [7:0] d, logic [15:0] c);
        @(negedge clk);
        en = 1'b1; din = d; cnt = c;
        @(negedge clk);
        en = 1'b0;
    endtask

    initial begin
        // Reset state, applied asynchronously between edges
        #2 rst_n = 1'b0;
        #1;
        chkv("reset_txd",  int'(txd[0]),  1);
        chkv("reset_busy", int'(busy[0]), 0);
        chkv("reset_done", int'(done[0]), 0);
        repeat (2) @(negedge clk);

        // 0x55, 4-cycle bits; request taken on the first edge after release
        rst_n = 1'b1; en = 1'b1; din = 8'h55; cnt = 16'd4;
        @(posedge clk); #1;
        chkv("start_txd",  int'(txd[0]),  0);
        chkv("start_busy", int'(busy[0]), 1);
        @(negedge clk); en = 1'b0;
        repeat (4) @(negedge clk);   // cycle 4: data bit 0
        chkv("55_bit0", int'(txd[0]), 1);
        repeat (4) @(negedge clk);   // cycle 8: data bit 1
        chkv("55_bit1", int'(txd[0]), 0);
        repeat (60) @(negedge clk); #1;
        chkv("55_busy_u0", bcnt[0], 40);
        chkv("55_done_u0", dcnt[0], 1);
        chkv("55_busy_u1", bcnt[1], 44);
        chkv("55_busy_u3", bcnt[3], 44);

        // Parity: 0x07 has odd popcount -> even parity 1, odd parity 0
        clr();
        send(8'h07, 16'd3);
        repeat (27) @(negedge clk); #1;   // cycle 27: parity bit
        chkv("par_even", int'(txd[1]), 1);
        chkv("par_odd",  int'(txd[2]), 0);
        repeat (40) @(negedge clk); #1;
        chkv("par_len_u1", bcnt[1], 33);
        chkv("par_len_u2", bcnt[2], 33);
        chkv("par_len_u0", bcnt[0], 30);
        chkv("par_done_u1", dcnt[1], 1);

        // Back-to-back with uart_en held high
        clr();
        @(negedge clk); en = 1'b1; din = 8'hA3; cnt = 16'd2;
        @(negedge clk); din = 8'h3C;      // cycle 0
        repeat (20) @(negedge clk); #1;   // cycle 20: done cycle for u0
        chkv("b2b_done", int'(done[0]), 1);
        chkv("b2b_busy", int'(busy[0]), 0);
        chkv("b2b_txd",  int'(txd[0]),  1);
        @(negedge clk); #1;               // cycle 21: next start bit
        chkv("b2b_start_txd",  int'(txd[0]),  0);
        chkv("b2b_start_busy", int'(busy[0]), 1);
        en = 1'b0;
        repeat (60) @(negedge clk); #1;
        chkv("b2b_frames_u0", dcnt[0], 2);
        chkv("b2b_busy_u0",   bcnt[0], 40);
        chkv("b2b_frames_u1", dcnt[1], 1);

        // Mid-frame period change and request while busy are ignored
        clr();
        send(8'h96, 16'd4);
        repeat (5) @(negedge clk);
        cnt = 16'd8; en = 1'b1;
        @(negedge clk); en = 1'b0;
        repeat (60) @(negedge clk); #1;
        chkv("busy_req_len",  bcnt[0], 40);
        chkv("busy_req_done", dcnt[0], 1);
        chkv("busy_req_u3",   dcnt[3], 1);

        // Reset during data bit 3 aborts the frame
        clr();
        send(8'h5A, 16'd4);
        repeat (17) @(negedge clk);       // cycle 17
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("abort_txd",  i, txd[i],  1'b1);
            chk("abort_busy", i, busy[i], 1'b0);
            chk("abort_done", i, done[i], 1'b0);
        end
        repeat (2) @(negedge clk); #1;
        chkv("abort_no_done", dcnt[0] + dcnt[1] + dcnt[2] + dcnt[3], 0);
        rst_n = 1'b1;
        clr();
        send(8'hC3, 16'd4);
        repeat (60) @(negedge clk); #1;
        chkv("post_reset_len",  bcnt[0], 40);
        chkv("post_reset_done", dcnt[0], 1);

        // uart_cnt=0 -> 1-cycle bits
        clr();
        send(8'hFF, 16'd0);
        repeat (20) @(negedge clk); #1;
        chkv("cnt0_len_u3", bcnt[3], 11);
        chkv("cnt0_low_u3", lcnt[3], 1);
        chkv("cnt0_len_u0", bcnt[0], 10);
        chkv("cnt0_done_u3", dcnt[3], 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving data bits per frame (legal range 5..9).
REQ-002 The block SHALL have parameter PARITY, default 0, selecting the parity bit: 0 none, 1 odd, 2 even.
REQ-003 The block SHALL have parameter STOP_BITS, default 1, giving the number of stop bits (legal values 1 or 2).
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 uart_cnt  input  16  clock cycles per bit period.
REQ-007 uart_en  input  1  transmit request; sampled only when not busy.
REQ-008 uart_din  input  DATA_WIDTH  byte to send; sampled with uart_en.
REQ-009 uart_txd  output  1  serial line; idle high.
REQ-010 uart_busy  output  1  high while a frame is in progress.
REQ-011 uart_done  output  1  one-cycle pulse at frame completion.

Function
REQ-012 The frame SHALL be 1 start bit (0), DATA_WIDTH data bits LSB first, 1 parity bit if PARITY!=0, then STOP_BITS stop bits (1).
REQ-013 FSM states: IDLE, START, DATA, PAR, STOP; transitions IDLE->START->DATA->(PAR if PARITY!=0)->STOP->IDLE.
REQ-014 Acceptance: at a rising edge where state is IDLE and uart_en=1:
- uart_din and uart_cnt are latched.
- Effective period = max(uart_cnt, 1).
- uart_txd goes 0 and uart_busy goes 1 after that same edge (zero-cycle start latency).
REQ-015 Each bit SHALL be held on uart_txd for exactly the latched period in cycles, driven by a 16-bit down-counter.
REQ-016 Changes to uart_cnt or uart_din during a frame SHALL NOT affect the frame in progress.
REQ-017 uart_en while uart_busy=1 SHALL be ignored: no queuing and no error flag.
REQ-018 The parity bit SHALL be the XOR of the latched data bits, inverted for odd parity (PARITY=1).
REQ-019 At the edge ending the last stop bit:
- state returns to IDLE; uart_busy goes 0; uart_done is 1 for exactly one cycle.
- uart_txd stays 1.
REQ-020 Back-to-back: if uart_en=1 in the uart_done cycle, the next start bit SHALL begin at the following edge, with no idle gap.
REQ-021 Total frame duration SHALL be (1+DATA_WIDTH+(PARITY!=0)+STOP_BITS) x period cycles, measured from txd falling to busy falling.
REQ-022 uart_txd SHALL be driven from a register (glitch-free).

Reset
REQ-023 On rst_n=0, immediately and regardless of clock:
- state IDLE, uart_txd 1, uart_busy 0, uart_done 0.
- all counters and data registers 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no uart_done pulse.
REQ-025 After rst_n deasserts, the first uart_en SHALL be accepted at the first rising edge.

Verification
REQ-026 DATA_WIDTH=8, PARITY=0, uart_cnt=4, uart_din=0x55 pulse -> txd bits 0,1,0,1,0,1,0,1,0,1 each 4 cycles; busy high 40 cycles; done one pulse.
REQ-027 PARITY=2, uart_cnt=3, uart_din=0x07 -> parity bit 1; PARITY=1 same data -> parity bit 0; frame 33 cycles.
REQ-028 uart_en held high continuously, uart_din 0xA3 then 0x3C, uart_cnt=2 -> two frames with txd falling the cycle after done; no idle gap.
REQ-029 uart_en pulse and uart_cnt changed 4->8 mid-frame, second uart_en while busy -> frame stays at 4-cycle bits; second request dropped.
REQ-030 rst_n low during data bit 3 -> txd=1 and busy=0 immediately, no done; next uart_en after release sends a full correct frame.
REQ-031 uart_cnt=0 and STOP_BITS=2 with 0xFF -> 1-cycle bits, 11-cycle frame, txd low for exactly 1 cycle.
